// File: rtl/sseg_pkg.sv
// Shared constants for the four-digit seven-segment driver.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low segment pattern.
// Non-decimal nibbles (A..F) render as a centre dash.
module bcd_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  import sseg_pkg::*;

  always_comb begin
    seg_n = SEG_DASH;
    case (nibble)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_mux4.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous
// BCD update, leading-zero blanking, decimal points and 8-level PWM.
module sseg_mux4 #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  input  logic [2:0]  brightness,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  import sseg_pkg::*;

  localparam int SUB_N = DIGIT_CYCLES / 8;
  localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(SUB_N - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [SUB_W-1:0] sub_cnt;
  logic [2:0]       phase;
  logic [DIG_W-1:0] digit_idx;
  logic [15:0]      disp_reg;
  logic [15:0]      pend_reg;
  logic             pending;
  logic             frame_start;

  logic sub_term, slot_end, boundary;

  assign sub_term = (sub_cnt == SUB_MAX);
  assign slot_end = sub_term && (phase == 3'd7);
  assign boundary = slot_end && (digit_idx == DIG_LAST);

  // Scan counters: sub-slot tick -> PWM phase -> digit index
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sub_cnt   <= '0;
      phase     <= 3'd0;
      digit_idx <= '0;
    end else begin
      sub_cnt <= sub_term ? '0 : sub_cnt + 1'b1;
      if (sub_term) phase <= phase + 3'd1;
      if (slot_end) digit_idx <= digit_idx + 1'b1;
    end
  end

  // Update handshake: disp_reg only moves on the frame boundary
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      disp_reg <= 16'h0000;
      pend_reg <= 16'h0000;
      pending  <= 1'b0;
    end else if (boundary) begin
      if (bcd_valid) begin
        disp_reg <= bcd_in;
        pending  <= 1'b0;
      end else if (pending) begin
        disp_reg <= pend_reg;
        pending  <= 1'b0;
      end
    end else if (bcd_valid) begin
      pend_reg <= bcd_in;
      pending  <= 1'b1;
    end
  end

  // Stage p0: select digit, blanking and PWM compare from current state
  logic [3:0] nibble_p0;
  logic [6:0] seg_p0;
  logic [3:0] blank_vec_p0;
  logic       upper_zero_p0;
  logic       lit_p0;

  assign nibble_p0 = disp_reg[{digit_idx, 2'b00} +: 4];

  always_comb begin
    upper_zero_p0 = 1'b1;
    blank_vec_p0  = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      upper_zero_p0   = upper_zero_p0 && (disp_reg[4*i +: 4] == 4'd0) && !dp_en[i];
      blank_vec_p0[i] = blank_lz && (i != 0) && upper_zero_p0;
    end
  end

  assign lit_p0 = (phase <= brightness) && !blank_vec_p0[digit_idx];

  bcd_to_7seg u_dec (
    .nibble (nibble_p0),
    .seg_n  (seg_p0)
  );

  // Stage p1: registered pin drivers; frame_tick lags the wrap by one
  // cycle so it lines up with the first digit-0 output
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      frame_tick  <= frame_start;
      if (lit_p0) begin
        an  <= ~(4'b0001 << digit_idx);
        seg <= seg_p0;
        dp  <= ~dp_en[digit_idx];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux4.sv
// Scoreboard bench for sseg_mux4 with DIGIT_CYCLES=16 (16-cycle slots,
// 64-cycle frames); expectations come from a frame-position model.
module tb_sseg_mux4;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        bcd_valid = 1'b0;
  logic [3:0]  dp_en = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } out_t;

  out_t exp_q[$];
  out_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Model state: cycles since reset plus the display/pending words
  int          t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pending = 1'b0;

  sseg_mux4 #(.DIGIT_CYCLES(16), .NUM_DIGITS(4)) dut (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Predict the outputs produced by the coming edge, advance the model,
  // then wait for the next falling edge where inputs are changed.
  task automatic cycle();
    out_t e;
    int   d, ph;
    bit   blanked;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
    if (reset) begin
      t = 0;
      m_disp = 16'h0000;
      m_pend = 16'h0000;
      m_pending = 1'b0;
    end else begin
      d  = (t % 64) / 16;
      ph = (t % 16) / 2;
      blanked = 1'b0;
      if (blank_lz && d > 0) begin
        blanked = 1'b1;
        for (int j = d; j < 4; j++)
          if (m_disp[4*j +: 4] != 4'd0 || dp_en[j]) blanked = 1'b0;
      end
      if (ph <= int'(brightness) && !blanked) begin
        e.an[d] = 1'b0;
        e.seg   = glyph(m_disp[4*d +: 4]);
        e.dp    = ~dp_en[d];
      end
      e.tick = (t % 64 == 0) && (t > 0);
      if (t % 64 == 63) begin
        if (bcd_valid) begin
          m_disp = bcd_in;
          m_pending = 1'b0;
        end else if (m_pending) begin
          m_disp = m_pend;
          m_pending = 1'b0;
        end
      end else if (bcd_valid) begin
        m_pend = bcd_in;
        m_pending = 1'b1;
      end
      t++;
    end
    exp_q.push_back(e);
    @(negedge CLK100MHZ);
  endtask

  task automatic strobe(input logic [15:0] val);
    bcd_in = val;
    bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    while (t % 64 != pos) cycle();
  endtask

  // Monitor: one comparison per clock whenever an expectation is queued
  initial begin
    forever begin
      @(posedge CLK100MHZ);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        tests++;
        if ({an, seg, dp, frame_tick} !== mon_e) begin
          fails++;
          $display("FAIL pins @%0t: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                   $time, an, seg, dp, frame_tick, mon_e.an, mon_e.seg, mon_e.dp, mon_e.tick);
        end
      end
    end
  end

  initial begin
    logic [15:0] rv;
    @(negedge CLK100MHZ);
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (70) cycle();

    // Load mid-frame, visible only from the next frame
    wait_pos(20);
    strobe(16'h1234);
    repeat (140) cycle();

    // Last strobe before the boundary wins
    wait_pos(20);
    strobe(16'h5678);
    wait_pos(36);
    strobe(16'h9999);
    repeat (80) cycle();

    // Strobe on the boundary cycle bypasses the pending register
    wait_pos(63);
    strobe(16'h2468);
    repeat (70) cycle();

    // Leading-zero blanking, then a decimal point holding digit 2 lit
    blank_lz = 1'b1;
    dp_en = 4'b0000;
    strobe(16'h0042);
    repeat (140) cycle();
    dp_en = 4'b0100;
    repeat (70) cycle();
    blank_lz = 1'b0;
    dp_en = 4'b0000;

    // PWM brightness levels over full frames
    brightness = 3'd1;
    wait_pos(0);
    repeat (64) cycle();
    brightness = 3'd7;
    repeat (64) cycle();
    brightness = 3'd0;
    repeat (64) cycle();
    brightness = 3'd7;

    // Invalid nibble renders as a dash
    strobe(16'h00A0);
    repeat (140) cycle();

    // Reset during digit 2 restarts the scan at digit 0 showing 0
    wait_pos(40);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (70) cycle();

    // Randomized traffic with zero-heavy words to exercise blanking
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 4; k++)
          rv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd_in = rv;
        bcd_valid = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) begin
        dp_en      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        brightness = 3'($urandom_range(0, 7));
        blank_lz   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      cycle();
      bcd_valid = 1'b0;
      reset = 1'b0;
    end

    repeat (3) @(posedge CLK100MHZ);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
